// File: rtl/int_to_float_if.sv
// Strobe-handshake bundle for the int_to_float converter: operand and start
// request in, IEEE-754 result, done pulse and busy flag out.
interface int_to_float_if;
  logic [31:0] a_value_i;
  logic        exec_strobe_i;
  logic [31:0] z_value_o;
  logic        done_strobe_o;
  logic        busy_o;

  modport master (
    output a_value_i,
    output exec_strobe_i,
    input  z_value_o,
    input  done_strobe_o,
    input  busy_o
  );

  modport slave (
    input  a_value_i,
    input  exec_strobe_i,
    output z_value_o,
    output done_strobe_o,
    output busy_o
  );
endinterface

// File: rtl/int_to_float.sv
// Sequential 32-bit integer to IEEE-754 single converter, one normalising shift per cycle.
// Define INT_TO_FLOAT_ROUND_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module int_to_float #(
  parameter bit SIGNED = 1'b1
) (
  input logic           clk,
  input logic           reset_i,
  int_to_float_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_a, w_a;
  logic        r_sign, w_sign;
  logic [31:0] r_m, w_m;
  logic [7:0]  r_exp, w_exp;
  logic [31:0] r_z, w_z;
  logic        r_done, w_done;

  logic [31:0] w_mag;
  logic [22:0] w_rsig;
  logic [7:0]  w_rexp;

  assign w_mag = (SIGNED && r_a[31]) ? (32'd0 - r_a) : r_a;

`ifdef INT_TO_FLOAT_ROUND_EN
  logic        w_inc;
  logic [23:0] w_sum;

  // m[31] is always set in ROUND, so a clear sum[23] means the increment wrapped
  // the significand to zero: that is the carry-out, and the fraction bits are already 0.
  assign w_inc  = r_m[7] & ((|r_m[6:0]) | r_m[8]);
  assign w_sum  = r_m[31:8] + {23'd0, w_inc};
  assign w_rsig = w_sum[22:0];
  assign w_rexp = r_exp + {7'd0, ~w_sum[23]};
`else
  assign w_rsig = r_m[30:8];
  assign w_rexp = r_exp;
`endif

  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_sign  = r_sign;
    w_m     = r_m;
    w_exp   = r_exp;
    w_z     = r_z;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.exec_strobe_i) begin
          w_a     = bus.a_value_i;
          w_state = S_UNPACK;
        end
      end
      S_UNPACK: begin
        w_sign = SIGNED & r_a[31];
        w_m    = w_mag;
        w_exp  = 8'd158;
        if (w_mag == '0) begin
          w_z     = '0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_state = S_NORM;
        end
      end
      S_NORM: begin
        if (r_m[31]) begin
          w_state = S_ROUND;
        end else begin
          w_m   = {r_m[30:0], 1'b0};
          w_exp = r_exp - 8'd1;
        end
      end
      S_ROUND: begin
        w_z     = {r_sign, w_rexp, w_rsig};
        w_done  = 1'b1;
        w_state = S_DONE;
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_sign  <= 1'b0;
      r_m     <= '0;
      r_exp   <= '0;
      r_z     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_sign  <= w_sign;
      r_m     <= w_m;
      r_exp   <= w_exp;
      r_z     <= w_z;
      r_done  <= w_done;
    end
  end

  assign bus.z_value_o     = r_z;
  assign bus.done_strobe_o = r_done;
  assign bus.busy_o        = (r_state != S_IDLE);

endmodule
